// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// mc_pkg : shared encodings for the multi-cycle control unit      rev 1.0
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_IF     = 4'd1,
    S_ID     = 4'd2,
    S_EX_R   = 4'd3,
    S_EX_I   = 4'd4,
    S_EX_MA  = 4'd5,
    S_EX_BR  = 4'd6,
    S_EX_J   = 4'd7,
    S_MEM_RD = 4'd8,
    S_MEM_WR = 4'd9,
    S_WB_R   = 4'd10,
    S_WB_I   = 4'd11,
    S_WB_LD  = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] BSEL_B      = 2'd0;
  localparam logic [1:0] BSEL_4      = 2'd1;
  localparam logic [1:0] BSEL_IMM    = 2'd2;
  localparam logic [1:0] BSEL_IMM_SH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mc_if.sv
`default_nettype none
// ============================================================================
// mc_if : control-unit <-> datapath/memory signal bundle           rev 1.0
// ============================================================================
interface mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       mem_iord;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       ab_we;
  logic       aluout_we;
  logic       mdr_we;
  logic       alu_a_sel;
  logic [1:0] alu_b_sel;
  logic [2:0] alu_op;
  logic       rf_we;
  logic       rf_dst_sel;
  logic       rf_wd_sel;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct, zero, mem_ack,
    output mem_req, mem_we, mem_iord, pc_we, pc_src, ir_we, ab_we, aluout_we,
           mdr_we, alu_a_sel, alu_b_sel, alu_op, rf_we, rf_dst_sel, rf_wd_sel,
           illegal, state_o
  );

  modport slave (
    output opcode, funct, zero, mem_ack,
    input  mem_req, mem_we, mem_iord, pc_we, pc_src, ir_we, ab_we, aluout_we,
           mdr_we, alu_a_sel, alu_b_sel, alu_op, rf_we, rf_dst_sel, rf_wd_sel,
           illegal, state_o
  );
endinterface
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// ============================================================================
// mc_alu_dec : opcode/funct -> ALU operation and legality decode   rev 1.0
// ============================================================================
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       dec_illegal
);

  always_comb begin
    alu_op      = ALU_ADD;
    dec_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_J: alu_op = ALU_ADD;
      OP_ANDI:                     alu_op = ALU_AND;
      OP_ORI:                      alu_op = ALU_OR;
      OP_BEQ, OP_BNE:              alu_op = ALU_SUB;
      default:                     dec_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// mc_ctrl : multi-cycle CPU control FSM with memory req/ack handshake rev 1.0
// ============================================================================
module mc_ctrl
  import mc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mc_if.master     bus
);

  state_e     state, state_nxt;
  logic [2:0] dec_op;
  logic       dec_illegal;

  logic       mem_req, mem_we, mem_iord, pc_we, ir_we, ab_we, aluout_we, mdr_we;
  logic       alu_a_sel, rf_we, rf_dst_sel, rf_wd_sel, illegal;
  logic [1:0] pc_src, alu_b_sel;
  logic [2:0] alu_op;

  mc_alu_dec u_dec (
    .opcode      (bus.opcode),
    .funct       (bus.funct),
    .alu_op      (dec_op),
    .dec_illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_RST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_iord   = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    ir_we      = 1'b0;
    ab_we      = 1'b0;
    aluout_we  = 1'b0;
    mdr_we     = 1'b0;
    alu_a_sel  = 1'b0;
    alu_b_sel  = BSEL_B;
    alu_op     = ALU_ADD;
    rf_we      = 1'b0;
    rf_dst_sel = 1'b0;
    rf_wd_sel  = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_RST: state_nxt = S_IF;
      S_IF: begin
        mem_req   = 1'b1;
        alu_b_sel = BSEL_4;
        // PC+4 is only committed together with the fetched word
        if (bus.mem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_ID;
        end
      end
      S_ID: begin
        ab_we     = 1'b1;
        aluout_we = 1'b1;
        alu_b_sel = BSEL_IMM_SH;
        case (bus.opcode)
          OP_RTYPE:                state_nxt = dec_illegal ? S_TRAP : S_EX_R;
          OP_ADDI, OP_ANDI, OP_ORI: state_nxt = S_EX_I;
          OP_LW, OP_SW:            state_nxt = S_EX_MA;
          OP_BEQ, OP_BNE:          state_nxt = S_EX_BR;
          OP_J:                    state_nxt = S_EX_J;
          default:                 state_nxt = S_TRAP;
        endcase
      end
      S_EX_R: begin
        alu_a_sel = 1'b1;
        alu_op    = dec_op;
        aluout_we = 1'b1;
        state_nxt = S_WB_R;
      end
      S_EX_I: begin
        alu_a_sel = 1'b1;
        alu_b_sel = BSEL_IMM;
        alu_op    = dec_op;
        aluout_we = 1'b1;
        state_nxt = S_WB_I;
      end
      S_EX_MA: begin
        alu_a_sel = 1'b1;
        alu_b_sel = BSEL_IMM;
        aluout_we = 1'b1;
        state_nxt = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_iord = 1'b1;
        if (bus.mem_ack) begin
          mdr_we    = 1'b1;
          state_nxt = S_WB_LD;
        end
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_iord = 1'b1;
        if (bus.mem_ack) state_nxt = S_IF;
      end
      S_EX_BR: begin
        alu_a_sel = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
        state_nxt = S_IF;
      end
      S_EX_J: begin
        pc_we     = 1'b1;
        pc_src    = PC_JUMP;
        state_nxt = S_IF;
      end
      S_WB_R: begin
        rf_we      = 1'b1;
        rf_dst_sel = 1'b1;
        state_nxt  = S_IF;
      end
      S_WB_I: begin
        rf_we     = 1'b1;
        state_nxt = S_IF;
      end
      S_WB_LD: begin
        rf_we     = 1'b1;
        rf_wd_sel = 1'b1;
        state_nxt = S_IF;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_nxt = S_RST;
    endcase
  end

  // reset silences every output in the same cycle, even mid memory wait
  assign bus.mem_req    = mem_req    & ~rst;
  assign bus.mem_we     = mem_we     & ~rst;
  assign bus.mem_iord   = mem_iord   & ~rst;
  assign bus.pc_we      = pc_we      & ~rst;
  assign bus.pc_src     = rst ? 2'd0 : pc_src;
  assign bus.ir_we      = ir_we      & ~rst;
  assign bus.ab_we      = ab_we      & ~rst;
  assign bus.aluout_we  = aluout_we  & ~rst;
  assign bus.mdr_we     = mdr_we     & ~rst;
  assign bus.alu_a_sel  = alu_a_sel  & ~rst;
  assign bus.alu_b_sel  = rst ? 2'd0 : alu_b_sel;
  assign bus.alu_op     = rst ? 3'd0 : alu_op;
  assign bus.rf_we      = rf_we      & ~rst;
  assign bus.rf_dst_sel = rf_dst_sel & ~rst;
  assign bus.rf_wd_sel  = rf_wd_sel  & ~rst;
  assign bus.illegal    = illegal    & ~rst;
  assign bus.state_o    = rst ? 4'd0 : state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mc_ctrl : self-checking bench for the multi-cycle control unit rev 1.0
// ============================================================================
module tb_mc_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_if bus ();
  mc_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       mem_req, mem_we, mem_iord, pc_we;
    logic [1:0] pc_src;
    logic       ir_we, ab_we, aluout_we, mdr_we, alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [2:0] alu_op;
    logic       rf_we, rf_dst_sel, rf_wd_sel, illegal;
    logic [3:0] state;
  } obs_t;

  typedef struct packed {
    logic ack;
    obs_t o;
  } cyc_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic [4:0] len;
    logic [2:0] ex_op;
    logic       ex_pcwe;
  } vec_t;

  cyc_t tq[$];

  function automatic obs_t get_obs();
    obs_t o;
    o.mem_req    = bus.mem_req;
    o.mem_we     = bus.mem_we;
    o.mem_iord   = bus.mem_iord;
    o.pc_we      = bus.pc_we;
    o.pc_src     = bus.pc_src;
    o.ir_we      = bus.ir_we;
    o.ab_we      = bus.ab_we;
    o.aluout_we  = bus.aluout_we;
    o.mdr_we     = bus.mdr_we;
    o.alu_a_sel  = bus.alu_a_sel;
    o.alu_b_sel  = bus.alu_b_sel;
    o.alu_op     = bus.alu_op;
    o.rf_we      = bus.rf_we;
    o.rf_dst_sel = bus.rf_dst_sel;
    o.rf_wd_sel  = bus.rf_wd_sel;
    o.illegal    = bus.illegal;
    o.state      = bus.state_o;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
    end
  endtask

  // ---------------- reference model: per-instruction cycle trace ----------------
  function automatic obs_t blank(input logic [3:0] s);
    obs_t o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic logic [2:0] ref_op(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: return 3'd0;
        6'h22: return 3'd1;
        6'h24: return 3'd2;
        6'h25: return 3'd3;
        default: return 3'd4;
      endcase
    end
    if (op == 6'h0C) return 3'd2;
    if (op == 6'h0D) return 3'd3;
    return 3'd0;
  endfunction

  task automatic push(input logic ack, input obs_t o);
    cyc_t c;
    c.ack = ack;
    c.o   = o;
    tq.push_back(c);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wif, input int wmem);
    obs_t o;
    for (int i = 0; i <= wif; i++) begin
      o = blank(S_IF);
      o.mem_req = 1'b1; o.alu_b_sel = 2'd1;
      if (i == wif) begin o.ir_we = 1'b1; o.pc_we = 1'b1; end
      push(i == wif, o);
    end
    o = blank(S_ID);
    o.ab_we = 1'b1; o.aluout_we = 1'b1; o.alu_b_sel = 2'd3;
    push(rnd_bit(), o);
    if (op == 6'h00) begin
      o = blank(S_EX_R);
      o.alu_a_sel = 1'b1; o.alu_op = ref_op(op, fn); o.aluout_we = 1'b1;
      push(rnd_bit(), o);
      o = blank(S_WB_R); o.rf_we = 1'b1; o.rf_dst_sel = 1'b1;
      push(rnd_bit(), o);
    end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D) begin
      o = blank(S_EX_I);
      o.alu_a_sel = 1'b1; o.alu_b_sel = 2'd2; o.alu_op = ref_op(op, fn); o.aluout_we = 1'b1;
      push(rnd_bit(), o);
      o = blank(S_WB_I); o.rf_we = 1'b1;
      push(rnd_bit(), o);
    end else if (op == 6'h23 || op == 6'h2B) begin
      o = blank(S_EX_MA);
      o.alu_a_sel = 1'b1; o.alu_b_sel = 2'd2; o.aluout_we = 1'b1;
      push(rnd_bit(), o);
      for (int i = 0; i <= wmem; i++) begin
        o = blank(op == 6'h23 ? S_MEM_RD : S_MEM_WR);
        o.mem_req = 1'b1; o.mem_iord = 1'b1; o.mem_we = (op == 6'h2B);
        o.mdr_we = (op == 6'h23) && (i == wmem);
        push(i == wmem, o);
      end
      if (op == 6'h23) begin
        o = blank(S_WB_LD); o.rf_we = 1'b1; o.rf_wd_sel = 1'b1;
        push(rnd_bit(), o);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o = blank(S_EX_BR);
      o.alu_a_sel = 1'b1; o.alu_op = 3'd1; o.pc_src = 2'd1;
      o.pc_we = (op == 6'h04) ? z : ~z;
      push(rnd_bit(), o);
    end else begin
      o = blank(S_EX_J); o.pc_we = 1'b1; o.pc_src = 2'd2;
      push(rnd_bit(), o);
    end
  endtask

  task automatic run_trace(output int ir_n, output int mdr_n);
    cyc_t c;
    obs_t o;
    ir_n = 0; mdr_n = 0;
    while (tq.size() > 0) begin
      c = tq.pop_front();
      bus.mem_ack = c.ack;
      @(negedge clk);
      o = get_obs();
      chk_obs($sformatf("trace_st%0d", c.o.state), o, c.o);
      ir_n  += int'(o.ir_we);
      mdr_n += int'(o.mdr_we);
      @(posedge clk); #1;
    end
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.opcode = op; bus.funct = fn; bus.zero = z;
  endtask

  // leaves the bench just after a rising edge with the DUT in IF
  task automatic do_reset();
    rst = 1'b1; bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_obs("rst_high_outs", get_obs(), '0);
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    chk_obs("rst_state_outs", get_obs(), '0);
    @(posedge clk); #1;
    chk("rst_to_if", 32'(bus.state_o), 32'(S_IF));
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
  endtask

  task automatic trap_test(input logic [5:0] op, input logic [5:0] fn, input string name);
    obs_t e;
    set_instr(op, fn, 1'b0); bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e = blank(S_TRAP); e.illegal = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.mem_ack = rnd_bit();
      @(negedge clk);
      chk_obs({name, "_hold"}, get_obs(), e);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_obs({name, "_rst_outs"}, get_obs(), '0);
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    chk({name, "_rst_state"}, 32'(bus.state_o), 32'(S_RST));
    chk({name, "_illegal_clr"}, 32'(bus.illegal), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[15];
  logic [11:0] legal[13];

  initial begin
    int n, ir_n, mdr_n, bad;
    logic [2:0] aop;
    logic pw;

    vecs[0]  = '{6'h00, 6'h20, 1'b0, 5'd4, 3'd0, 1'b0};
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 5'd4, 3'd1, 1'b0};
    vecs[2]  = '{6'h00, 6'h24, 1'b1, 5'd4, 3'd2, 1'b0};
    vecs[3]  = '{6'h00, 6'h25, 1'b0, 5'd4, 3'd3, 1'b0};
    vecs[4]  = '{6'h00, 6'h2A, 1'b0, 5'd4, 3'd4, 1'b0};
    vecs[5]  = '{6'h08, 6'h3F, 1'b0, 5'd4, 3'd0, 1'b0};
    vecs[6]  = '{6'h0C, 6'h00, 1'b0, 5'd4, 3'd2, 1'b0};
    vecs[7]  = '{6'h0D, 6'h11, 1'b1, 5'd4, 3'd3, 1'b0};
    vecs[8]  = '{6'h23, 6'h00, 1'b0, 5'd5, 3'd0, 1'b0};
    vecs[9]  = '{6'h2B, 6'h00, 1'b0, 5'd4, 3'd0, 1'b0};
    vecs[10] = '{6'h04, 6'h00, 1'b1, 5'd3, 3'd1, 1'b1};
    vecs[11] = '{6'h04, 6'h00, 1'b0, 5'd3, 3'd1, 1'b0};
    vecs[12] = '{6'h05, 6'h00, 1'b1, 5'd3, 3'd1, 1'b0};
    vecs[13] = '{6'h05, 6'h00, 1'b0, 5'd3, 3'd1, 1'b1};
    vecs[14] = '{6'h02, 6'h00, 1'b0, 5'd3, 3'd0, 1'b1};

    legal = '{12'h020, 12'h022, 12'h024, 12'h025, 12'h02A, {6'h08, 6'h00},
              {6'h0C, 6'h00}, {6'h0D, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00},
              {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00}};

    set_instr(6'h00, 6'h20, 1'b0);
    bus.mem_ack = 1'b0;
    do_reset();

    // table: cycles per instruction plus EX-cycle alu_op / pc_we, zero-wait memory
    foreach (vecs[k]) begin
      set_instr(vecs[k].op, vecs[k].fn, vecs[k].z);
      bus.mem_ack = 1'b1;
      n = 0; aop = 3'd7; pw = 1'bx;
      do begin
        @(negedge clk);
        if (n == 2) begin aop = bus.alu_op; pw = bus.pc_we; end
        @(posedge clk); #1;
        n++;
      end while (bus.state_o != 4'(S_IF) && n < 20);
      chk($sformatf("vec%0d_cycles", k), 32'(n), 32'(vecs[k].len));
      chk($sformatf("vec%0d_alu_op", k), 32'(aop), 32'(vecs[k].ex_op));
      chk($sformatf("vec%0d_pc_we", k), 32'(pw), 32'(vecs[k].ex_pcwe));
      if (bus.state_o != 4'(S_IF)) do_reset();
    end

    // add with ack tied high: full per-cycle trace
    set_instr(6'h00, 6'h20, 1'b0);
    model_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_trace(ir_n, mdr_n);

    // lw with two wait cycles on both fetch and data read
    set_instr(6'h23, 6'h00, 1'b0);
    model_instr(6'h23, 6'h00, 1'b0, 2, 2);
    run_trace(ir_n, mdr_n);
    chk("lw_wait_ir_pulses", 32'(ir_n), 32'd1);
    chk("lw_wait_mdr_pulses", 32'(mdr_n), 32'd1);
    chk("lw_wait_back_if", 32'(bus.state_o), 32'(S_IF));

    trap_test(6'h3F, 6'h20, "trap_op");
    trap_test(6'h00, 6'h07, "trap_fn");

    // sw interrupted by reset while waiting for the write ack
    bad = 0;
    set_instr(6'h2B, 6'h00, 1'b0); bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("sw_wait_bus", 32'({bus.mem_req, bus.mem_we, bus.mem_iord}), 32'h7);
      chk("sw_wait_state", 32'(bus.state_o), 32'(S_MEM_WR));
      @(posedge clk); #1;
    end
    rst = 1'b1; bus.mem_ack = 1'b1;
    @(negedge clk);
    bad += int'(bus.mem_we & bus.mem_ack);
    chk("sw_rst_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    bad += int'(bus.mem_we & bus.mem_ack);
    chk("sw_rst_state", 32'(bus.state_o), 32'(S_RST));
    chk("sw_rst_req2", 32'(bus.mem_req), 32'd0);
    chk("sw_rst_no_write", 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk("sw_rst_to_if", 32'(bus.state_o), 32'(S_IF));

    // randomized instruction stream with random wait states
    for (int i = 0; i < 150; i++) begin
      logic [11:0] pick;
      logic z;
      pick = legal[$urandom_range(0, 12)];
      z = rnd_bit();
      set_instr(pick[11:6], pick[5:0], z);
      model_instr(pick[11:6], pick[5:0], z, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_trace(ir_n, mdr_n);
      chk("rand_ir_once", 32'(ir_n), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
